// File: rtl/keypad_lock_pkg.sv
// Shared types and helpers for the keypad lock: FSM state encoding and PIN digit extraction.
package keypad_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_LOCKOUT  = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_PROGRAM  = 2'd3
  } keypad_lock_state_t;

  localparam int MAX_PIN_W = 256;
  localparam int MAX_DIG_W = 32;

  // Digit i of a packed PIN (digit 0 in the LSBs); caller truncates to its digit width.
  function automatic logic [MAX_DIG_W-1:0] pin_digit(input logic [MAX_PIN_W-1:0] pin,
                                                      input int i, input int w);
    return MAX_DIG_W'(pin >> (i * w));
  endfunction

endpackage

// File: rtl/keypad_lock_if.sv
// Digit stream in, lock status out. master = keypad/driver side, slave = the lock.
interface keypad_lock_if #(
  parameter int DATA_W = 8,
  parameter int FC_W   = 2
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              relock;
  logic              prog;
  logic              unlocked;
  logic              locked_out;
  logic              programming;
  logic [FC_W-1:0]   fail_count;

  modport master (
    output din, din_valid, relock, prog,
    input  unlocked, locked_out, programming, fail_count
  );

  modport slave (
    input  din, din_valid, relock, prog,
    output unlocked, locked_out, programming, fail_count
  );
endinterface

// File: rtl/keypad_lock_timer.sv
// Loadable down-counter with zero flag; shared by lockout and idle-relock timing.
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)                       count_d = load_val;
    else if (dec && count_q != '0)  count_d = count_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign zero = (count_q == '0);
endmodule

// File: rtl/keypad_lock.sv
// PIN-entry lock: judges a full PIN per attempt, locks out after repeated failures,
// optionally auto-relocks when idle, and accepts a new PIN while unlocked.
module keypad_lock
  import keypad_lock_pkg::*;
#(
  parameter int                          DATA_W         = 8,
  parameter int                          PIN_LEN        = 4,
  parameter logic [PIN_LEN*DATA_W-1:0]   DEFAULT_PIN    = 32'hdec0adba,
  parameter int                          MAX_TRIES      = 3,
  parameter int                          LOCKOUT_CYCLES = 16,
  parameter int                          RELOCK_CYCLES  = 0
) (
  input logic           clk,
  input logic           reset_n,
  keypad_lock_if.slave  bus
);
  localparam int PIN_W   = PIN_LEN * DATA_W;
  localparam int IDX_W   = (PIN_LEN > 1) ? $clog2(PIN_LEN) : 1;
  localparam int FC_W    = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIN_LEN - 1);
  // Timer holds the cycles remaining after the loading edge, so it exits on the edge it reads zero.
  localparam logic [TMR_W-1:0] LOCK_LOAD   = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] RELOCK_LOAD = (RELOCK_CYCLES == 0) ? '0 : TMR_W'(RELOCK_CYCLES - 1);

  keypad_lock_state_t state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               miss_q, miss_d;
  logic [FC_W-1:0]    fail_q, fail_d;
  logic [PIN_W-1:0]   pin_q, pin_d;
  logic [PIN_W-1:0]   shadow_q, shadow_d;

  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]   tmr_val;
  logic               digit_ok, last;

  assign digit_ok = (bus.din == DATA_W'(pin_digit(MAX_PIN_W'(pin_q), int'(idx_q), DATA_W)));
  assign last     = (idx_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    miss_d   = miss_q;
    fail_d   = fail_q;
    pin_d    = pin_q;
    shadow_d = shadow_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      ST_ENTRY: if (bus.din_valid) begin
        if (last) begin
          idx_d  = '0;
          miss_d = 1'b0;
          if (!miss_q && digit_ok) begin
            state_d  = ST_UNLOCKED;
            fail_d   = '0;
            tmr_load = 1'b1;
            tmr_val  = RELOCK_LOAD;
          end else if (fail_q == FC_W'(MAX_TRIES - 1)) begin
            state_d  = ST_LOCKOUT;
            fail_d   = '0;
            tmr_load = 1'b1;
            tmr_val  = LOCK_LOAD;
          end else begin
            fail_d = fail_q + FC_W'(1);
          end
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          miss_d = miss_q | ~digit_ok;
        end
      end
      ST_LOCKOUT: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
        end
      end
      ST_UNLOCKED: begin
        tmr_dec = 1'b1;
        if (bus.relock) begin
          state_d = ST_ENTRY;
        end else if (bus.din_valid && bus.prog) begin
          // idx is 0 here, so last only holds for single-digit PINs: commit at once.
          shadow_d[idx_q*DATA_W +: DATA_W] = bus.din;
          if (last) begin
            pin_d   = shadow_d;
            state_d = ST_ENTRY;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_PROGRAM;
          end
        end else if (bus.din_valid) begin
          tmr_load = 1'b1;
          tmr_val  = RELOCK_LOAD;
        end else if (RELOCK_CYCLES != 0 && tmr_zero) begin
          state_d = ST_ENTRY;
        end
      end
      ST_PROGRAM: begin
        if (bus.relock) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
        end else if (bus.din_valid) begin
          shadow_d[idx_q*DATA_W +: DATA_W] = bus.din;
          if (last) begin
            pin_d   = shadow_d;
            state_d = ST_ENTRY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_ENTRY;
      idx_q    <= '0;
      miss_q   <= 1'b0;
      fail_q   <= '0;
      pin_q    <= DEFAULT_PIN;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      miss_q   <= miss_d;
      fail_q   <= fail_d;
      pin_q    <= pin_d;
      shadow_q <= shadow_d;
    end
  end

  lock_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign bus.unlocked    = (state_q == ST_UNLOCKED);
  assign bus.locked_out  = (state_q == ST_LOCKOUT);
  assign bus.programming = (state_q == ST_PROGRAM);
  assign bus.fail_count  = fail_q;
endmodule

// File: tb/tb_keypad_lock.sv
// Directed bench: default lock (no auto-relock) plus a second instance with RELOCK_CYCLES=5.
module tb_keypad_lock;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] din = 8'h00;
  logic din_valid = 1'b0, relock = 1'b0, prog = 1'b0, sel = 1'b0;
  int checks = 0, errors = 0;

  keypad_lock_if #(.DATA_W(8), .FC_W(2)) a ();
  keypad_lock_if #(.DATA_W(8), .FC_W(2)) b ();

  assign a.din = din;  assign a.din_valid = din_valid & ~sel;
  assign a.relock = relock & ~sel;  assign a.prog = prog & ~sel;
  assign b.din = din;  assign b.din_valid = din_valid & sel;
  assign b.relock = relock & sel;   assign b.prog = prog & sel;

  keypad_lock dut (.clk(clk), .reset_n(reset_n), .bus(a));
  keypad_lock #(.RELOCK_CYCLES(5)) dut_r (.clk(clk), .reset_n(reset_n), .bus(b));

  logic       unl, lko, prg;
  logic [1:0] fc;
  assign unl = sel ? b.unlocked    : a.unlocked;
  assign lko = sel ? b.locked_out  : a.locked_out;
  assign prg = sel ? b.programming : a.programming;
  assign fc  = sel ? b.fail_count  : a.fail_count;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d);
    din = d; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic send_pin(input logic [31:0] p);
    for (int i = 0; i < 4; i++) send(p[i*8 +: 8]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_unlocked", 32'(unl), 0);
    chk("rst_locked_out", 32'(lko), 0);
    chk("rst_programming", 32'(prg), 0);
    chk("rst_fail_count", 32'(fc), 0);
    reset_n = 1'b1;
    step();

    // Default PIN unlocks on the 4th digit
    send(8'hba); send(8'had); send(8'hc0);
    chk("pin_3of4_locked", 32'(unl), 0);
    send(8'hde);
    chk("pin_unlocked", 32'(unl), 1);
    chk("pin_fail0", 32'(fc), 0);
    relock = 1'b1; step(); relock = 1'b0;
    chk("relock_low", 32'(unl), 0);

    // Wrong first digit judged only at the end
    send(8'h00); send(8'had); send(8'hc0);
    chk("bad_mid_fail", 32'(fc), 0);
    chk("bad_mid_lko", 32'(lko), 0);
    send(8'hde);
    chk("bad1_fail", 32'(fc), 1);
    chk("bad1_unl", 32'(unl), 0);
    chk("bad1_lko", 32'(lko), 0);
    send_pin(32'h00000000);
    chk("bad2_fail", 32'(fc), 2);

    // Third failure: lockout for 16 cycles, digits ignored
    send_pin(32'h11111111);
    chk("bad3_lko", 32'(lko), 1);
    chk("bad3_fail_clr", 32'(fc), 0);
    din = 8'hba; din_valid = 1'b1;
    for (int k = 1; k < 16; k++) begin
      step();
      chk($sformatf("lockout_c%0d", k), 32'(lko), 1);
    end
    din_valid = 1'b0;
    step();
    chk("lockout_end", 32'(lko), 0);
    chk("lockout_end_unl", 32'(unl), 0);
    send_pin(32'hdec0adba);
    chk("post_lockout_unl", 32'(unl), 1);

    // Program 11,22,33,44
    prog = 1'b1; send(8'h11); prog = 1'b0;
    chk("prog_d1", 32'(prg), 1);
    send(8'h22); send(8'h33);
    chk("prog_d3", 32'(prg), 1);
    send(8'h44);
    chk("prog_done", 32'(prg), 0);
    chk("prog_done_unl", 32'(unl), 0);
    send_pin(32'hdec0adba);
    chk("old_pin_fails", 32'(fc), 1);
    chk("old_pin_unl", 32'(unl), 0);
    send_pin(32'h44332211);
    chk("new_pin_unl", 32'(unl), 1);
    chk("new_pin_fail0", 32'(fc), 0);

    // Abort programming with relock colliding with a digit
    prog = 1'b1; send(8'h55); prog = 1'b0;
    send(8'h66);
    din = 8'h77; din_valid = 1'b1; relock = 1'b1;
    step();
    din_valid = 1'b0; relock = 1'b0;
    chk("abort_prg", 32'(prg), 0);
    chk("abort_unl", 32'(unl), 0);
    send_pin(32'h44332211);
    chk("abort_keeps_pin", 32'(unl), 1);

    // Reset mid-program restores DEFAULT_PIN
    prog = 1'b1; send(8'h99); prog = 1'b0;
    send(8'haa);
    chk("midprog_prg", 32'(prg), 1);
    reset_n = 1'b0; step();
    chk("midprog_rst_prg", 32'(prg), 0);
    chk("midprog_rst_unl", 32'(unl), 0);
    reset_n = 1'b1; step();
    send_pin(32'hdec0adba);
    chk("default_restored", 32'(unl), 1);

    // Auto-relock instance
    sel = 1'b1; step();
    send_pin(32'hdec0adba);
    chk("ar_unl", 32'(unl), 1);
    for (int k = 1; k < 5; k++) begin
      step();
      chk($sformatf("ar_idle%0d", k), 32'(unl), 1);
    end
    step();
    chk("ar_relocked", 32'(unl), 0);
    send_pin(32'hdec0adba);
    chk("ar_unl2", 32'(unl), 1);
    step(); step(); step();
    send(8'h5a);
    chk("ar_restart", 32'(unl), 1);
    for (int k = 1; k < 5; k++) begin
      step();
      chk($sformatf("ar_restart_idle%0d", k), 32'(unl), 1);
    end
    step();
    chk("ar_relocked2", 32'(unl), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_lock.md
# keypad_lock

Parametrised successor to the fixed four-byte safe: a PIN-entry lock with configurable digit width, PIN length, retry budget, timed lockout, optional auto-relock and a code-change mode. It sits between the input byte stream (din/din_valid) and any logic gated by `unlocked`. Wrong digits are not revealed early; the PIN is judged only after all digits arrive. The stored PIN is reprogrammable while unlocked.

## Interface
- DATA_W, 8: digit width in bits.
- PIN_LEN, 4: digits per PIN, at least 1.
- DEFAULT_PIN, 32'hdec0adba: reset PIN, PIN_LEN*DATA_W bits; digit 0 in LSBs.
- MAX_TRIES, 3: consecutive failed PINs that trigger lockout, at least 1.
- LOCKOUT_CYCLES, 16: lockout duration in clocks, at least 1.
- RELOCK_CYCLES, 0: idle clocks in UNLOCKED before auto-relock; 0 disables auto-relock.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- din  in  DATA_W  digit.
- din_valid  in  1  digit strobe; one digit per cycle when high.
- relock  in  1  pulse; returns UNLOCKED/PROGRAM to ENTRY.
- prog  in  1  qualifies din_valid in UNLOCKED as a new-code digit.
- unlocked  out  1  high in UNLOCKED.
- locked_out  out  1  high in LOCKOUT.
- programming  out  1  high in PROGRAM.
- fail_count  out  $clog2(MAX_TRIES+1)  consecutive failed attempts.

## Operation
States: ENTRY, LOCKOUT, UNLOCKED, PROGRAM.

Reset (reset_n low) behaviour:
- State becomes ENTRY; stored PIN becomes DEFAULT_PIN.
- Digit index, match flag, fail_count and timers all clear.
- All outputs are 0.

ENTRY:
- Each din_valid compares din against stored digit[idx] and ANDs the result into the match flag; idx then increments.
- On digit PIN_LEN-1, the attempt is judged:
  - Match: go to UNLOCKED and clear fail_count.
  - Mismatch, fail_count+1 < MAX_TRIES: increment fail_count, stay in ENTRY, reset idx and match flag.
  - Mismatch, fail_count+1 == MAX_TRIES: go to LOCKOUT, clear fail_count, load the timer with LOCKOUT_CYCLES.
- relock and prog are ignored.

LOCKOUT:
- din_valid, relock and prog are ignored.
- The timer decrements each cycle; when it reaches zero, go to ENTRY with idx 0.

UNLOCKED (priority order):
- relock: go to ENTRY.
- din_valid && prog: write din to shadow digit 0, set idx to 1, go to PROGRAM.
- din_valid without prog: ignored, but restarts the idle timer.
- Auto-relock: if RELOCK_CYCLES != 0, RELOCK_CYCLES consecutive cycles without din_valid returns to ENTRY.

PROGRAM:
- Each din_valid writes shadow digit[idx].
- The PIN_LEN-th digit copies the whole shadow register into the stored PIN in one edge, then goes to ENTRY.
- relock aborts: go to ENTRY, stored PIN unchanged.
- prog is don't-care after entry.
- No auto-relock in PROGRAM.

Boundaries:
- PIN_LEN=1: the attempt is judged on every digit.
- idx wraps to 0 on every exit from ENTRY or PROGRAM.
- relock and din_valid in the same cycle in PROGRAM: relock wins; the digit is dropped.
- Reset mid-attempt or mid-program: everything is discarded, including any uncommitted new PIN; the stored PIN reverts to DEFAULT_PIN.

## Timing
- Outputs are decoded from registered state, so each changes the cycle after the causing edge:
  - Final correct digit sampled at edge N: unlocked high from N.
  - Final failing digit at edge N: fail_count updates at N; locked_out rises at N if the budget is exhausted.
- locked_out stays high for exactly LOCKOUT_CYCLES clocks; the first digit is accepted on the following edge.
- relock at edge N: unlocked low after N.
- Auto-relock: falls after RELOCK_CYCLES idle edges counted from entry to UNLOCKED or from the last din_valid.
- New PIN is in effect for the very next ENTRY digit after commit.
- Back-to-back din_valid is fully supported; no backpressure.

## Structure
- Package keypad_lock_pkg holds the state enum (keypad_lock_state_t, 2 bits) and a helper to extract digit i from a packed PIN.
- One sub-module, lock_timer: a loadable down-counter with a zero flag and width parameter, instanced once for both lockout and idle relock. Loads are mutually exclusive by state.
- The comparator and shadow register stay in the top module.

## Test plan
- Reset, then din ba,ad,c0,de on consecutive cycles: unlocked rises after the 4th edge; fail_count=0.
- Wrong first digit 00,ad,c0,de: no lockout mid-attempt; after the 4th digit, fail_count=1 and state stays ENTRY.
- Three bad PINs: locked_out high for exactly 16 cycles and digits ignored during it; then the correct PIN unlocks.
- Unlock, then prog with 11,22,33,44: programming high for 4 digits, then ENTRY. 11,22,33,44 unlocks; ba,ad,c0,de fails.
- PROGRAM with relock after 2 digits: old PIN still unlocks. Reset_n pulsed mid-program: DEFAULT_PIN restored.
- RELOCK_CYCLES=5: unlock, idle 5 cycles, unlocked falls. A din_valid at idle cycle 4 restarts the count.
